// File: rtl/multisim_packer_pkg.sv
// Shared types and helpers for the multisim push packer.
//   lane_cnt_t    : lane count type for the default configuration (RATIO=8)
//   packed_word_t : packed word plus lane count for the default configuration
//   merge_lane    : places one beat into its lane of a packed word; lanes not yet
//                   written stay at whatever the accumulator holds (zero after clear)
// The top derives its own widths from its parameters; the helper is width-generic
// up to MAX_DATA_WIDTH bits so it serves any legal override.
package multisim_packer_pkg;

  localparam int unsigned DEF_IN_WIDTH   = 8;
  localparam int unsigned DEF_RATIO      = 8;
  localparam int unsigned DEF_DATA_WIDTH = DEF_IN_WIDTH * DEF_RATIO;
  localparam int unsigned MAX_DATA_WIDTH = 1024;

  typedef logic [$clog2(DEF_RATIO+1)-1:0] lane_cnt_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    lane_cnt_t                 lanes;
  } packed_word_t;

  function automatic logic [MAX_DATA_WIDTH-1:0] merge_lane(
    input logic [MAX_DATA_WIDTH-1:0] acc,
    input logic [MAX_DATA_WIDTH-1:0] beat,
    input int unsigned               lane,
    input int unsigned               in_width
  );
    return acc | (beat << (lane * in_width));
  endfunction

endpackage

// File: rtl/multisim_sync_fifo.sv
// Single-clock FIFO with registered storage and head read-out.
//   clk, rst_n : clock, asynchronous active-low reset (contents cleared)
//   push, wr_data : write request/data, ignored when full
//   pop, rd_data  : read request, ignored when empty; rd_data is the current head
//   full, empty, count : occupancy status
// DEPTH must be a power of two; pointers wrap by natural overflow.
module multisim_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multisim_push_packer.sv
// Packs narrow IN_WIDTH beats into IN_WIDTH*RATIO words (first beat in the LSBs)
// and buffers them for the multisim push server.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_vld/in_rdy       : input beat handshake; in_rdy depends on registered state only
//   in_data, in_last    : beat payload; in_last closes the word, upper lanes zero
//   out_vld/out_rdy     : packed word handshake toward the server
//   out_data, out_lanes : FIFO head word and its number of valid beats (1..RATIO)
// Optional feature: define MULTISIM_PUSH_PACKER_TIMEOUT_EN to flush a partial word
// after TIMEOUT_CYCLES idle cycles.
module multisim_push_packer
  import multisim_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = 8,
  parameter int unsigned RATIO          = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_last,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [IN_WIDTH*RATIO-1:0]    out_data,
  output logic [$clog2(RATIO+1)-1:0]   out_lanes
);

  localparam int unsigned DATA_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned LW         = $clog2(RATIO+1);
  localparam int unsigned IW         = $clog2(RATIO);
  localparam int unsigned CW         = $clog2(FIFO_DEPTH+1);

  logic [IW-1:0]            lane_idx;
  logic [DATA_WIDTH-1:0]    acc;
  logic [DATA_WIDTH-1:0]    merged;
  logic                     accept;
  logic                     complete;
  logic                     flush_now;
  logic                     push;
  logic [DATA_WIDTH+LW-1:0] push_word;
  logic [DATA_WIDTH+LW-1:0] head_word;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_count_unused;

  assign fifo_count_unused = ^fifo_count;

  // Flush cycle blocks input so the partial word is queued before any later beat.
  assign in_rdy  = !fifo_full && !flush_now;
  assign accept  = in_vld && in_rdy;
  assign out_vld = !fifo_empty;
  assign {out_data, out_lanes} = head_word;

  always_comb begin
    merged    = DATA_WIDTH'(merge_lane(MAX_DATA_WIDTH'(acc), MAX_DATA_WIDTH'(in_data),
                                       32'(lane_idx), IN_WIDTH));
    complete  = accept && ((lane_idx == IW'(RATIO-1)) || in_last);
    push      = complete || flush_now;
    push_word = {acc, LW'(lane_idx)};
    if (complete) push_word = {merged, LW'(lane_idx) + LW'(1)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx <= '0;
      acc      <= '0;
    end else if (complete || flush_now) begin
      lane_idx <= '0;
      acc      <= '0;
    end else if (accept) begin
      lane_idx <= lane_idx + IW'(1);
      acc      <= merged;
    end
  end

`ifdef MULTISIM_PUSH_PACKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES+1);

  logic [TW-1:0] idle_cnt;

  // Counter saturates at the limit so a flush blocked by a full FIFO stays pending.
  assign flush_now = (lane_idx != '0) && (idle_cnt == TW'(TIMEOUT_CYCLES)) && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (accept || flush_now || (lane_idx == '0)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TW'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  assign flush_now = 1'b0;
`endif

  multisim_sync_fifo #(
    .WIDTH (DATA_WIDTH + LW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_word),
    .pop     (out_vld && out_rdy),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_multisim_push_packer.sv
module tb_multisim_push_packer;

  localparam int unsigned IN_WIDTH       = 8;
  localparam int unsigned RATIO          = 8;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned DW             = IN_WIDTH * RATIO;
  localparam int unsigned LW             = $clog2(RATIO+1);

  logic                clk;
  logic                rst_n;
  logic                in_vld;
  logic                in_rdy;
  logic [IN_WIDTH-1:0] in_data;
  logic                in_last;
  logic                out_vld;
  logic                out_rdy;
  logic [DW-1:0]       out_data;
  logic [LW-1:0]       out_lanes;

  multisim_push_packer #(
    .IN_WIDTH       (IN_WIDTH),
    .RATIO          (RATIO),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_lanes (out_lanes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   lanes;
  } exp_t;

  exp_t                exp_q[$];
  logic [IN_WIDTH-1:0] cur_beats[$];

  logic [DW-1:0] last_data;
  int unsigned   last_lanes;

  // out_rdy source: either a forced level or a random level refreshed each cycle
  bit   rnd_mode  = 1'b0;
  logic rdy_force = 1'b1;
  logic rnd_bit   = 1'b1;
  assign out_rdy = rnd_mode ? rnd_bit : rdy_force;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is just the list of beats collected so far, laid out lane by lane.
  function automatic void model_close();
    exp_t e;
    e.data  = '0;
    e.lanes = cur_beats.size();
    for (int i = 0; i < cur_beats.size(); i++) e.data[i*IN_WIDTH +: IN_WIDTH] = cur_beats[i];
    exp_q.push_back(e);
    cur_beats.delete();
  endfunction

  function automatic void model_accept(input logic [IN_WIDTH-1:0] d, input logic last);
    cur_beats.push_back(d);
    if (last || cur_beats.size() == RATIO) model_close();
  endfunction

  // Monitor: scoreboard compare on each output handshake, plus hold-stability while stalled.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] held_data;
  logic [LW-1:0] held_lanes;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_vld) begin
        check("hold_data", 64'(out_data), 64'(held_data));
        check("hold_lanes", 64'(out_lanes), 64'(held_lanes));
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h lanes %0d expected no word", out_data, out_lanes);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", 64'(out_data), 64'(e.data));
          check("word_lanes", 64'(out_lanes), 64'(e.lanes));
        end
        last_data  = out_data;
        last_lanes = out_lanes;
      end
      prev_stall = out_vld && !out_rdy;
      held_data  = out_data;
      held_lanes = out_lanes;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IN_WIDTH-1:0] d, input logic last, input int unsigned max_idle);
    bit r;
    bit ok;
    in_vld  = 1'b0;
    in_last = 1'b0;
    repeat ($urandom_range(max_idle)) step();
    in_vld  = 1'b1;
    in_data = d;
    in_last = last;
    ok      = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      r = in_rdy;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_vld  = 1'b0;
    in_last = 1'b0;
    if (ok) begin
      model_accept(d, last);
    end else begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: beat 0x%0h not accepted within 500 cycles, required acceptance", d);
    end
  endtask

  task automatic wait_drain(input string name, input int unsigned bound);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check({name, "_idle"}, 64'(out_vld), 64'd0);
    step();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    int unsigned seen;
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_lanes", 64'(out_lanes), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    step();

    // full word of 8 beats
    for (int i = 1; i <= 8; i++) send_beat(IN_WIDTH'(i), 1'b0, 0);
    wait_drain("t1_drain", 20);
    check("t1_data", 64'(last_data), 64'h0807060504030201);
    check("t1_lanes", 64'(last_lanes), 64'd8);

    // short word closed by in_last
    send_beat(8'hAA, 1'b0, 0);
    send_beat(8'hBB, 1'b1, 0);
    wait_drain("t2_drain", 20);
    check("t2_data", 64'(last_data), 64'h000000000000BBAA);
    check("t2_lanes", 64'(last_lanes), 64'd2);

    // in_last on first beat; in_last without in_vld is ignored
    in_last = 1'b1;
    step();
    in_last = 1'b0;
    send_beat(8'h5C, 1'b1, 0);
    wait_drain("t2b_drain", 20);
    check("t2b_lanes", 64'(last_lanes), 64'd1);

    // backpressure: fill FIFO with 4 words
    rdy_force = 1'b0;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 8; b++) send_beat(IN_WIDTH'($urandom), 1'b0, 0);
    @(negedge clk);
    check("t3_full_in_rdy", 64'(in_rdy), 64'd0);
    check("t3_full_out_vld", 64'(out_vld), 64'd1);
    step();
    in_vld  = 1'b1;
    in_data = 8'h77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_in_rdy", 64'(in_rdy), 64'd0);
      step();
    end
    in_vld    = 1'b0;
    rdy_force = 1'b1;
    @(negedge clk);
    check("t3_pop_cycle_in_rdy", 64'(in_rdy), 64'd0);
    step();
    @(negedge clk);
    check("t3_after_pop_in_rdy", 64'(in_rdy), 64'd1);
    step();
    for (int b = 0; b < 8; b++) send_beat(IN_WIDTH'($urandom), 1'b0, 0);
    wait_drain("t3_drain", 60);

    // mid-operation reset with 2 queued words and a 3-lane partial
    rdy_force = 1'b0;
    for (int b = 0; b < 19; b++) send_beat(IN_WIDTH'($urandom), 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_vld", 64'(out_vld), 64'd0);
    check("t5_rst_out_lanes", 64'(out_lanes), 64'd0);
    exp_q.delete();
    cur_beats.delete();
    step();
    step();
    rst_n     = 1'b1;
    rdy_force = 1'b1;
    step();
    for (int i = 0; i < 8; i++) send_beat(IN_WIDTH'(8'h11 + i), 1'b0, 0);
    wait_drain("t5_drain", 20);
    check("t5_data", 64'(last_data), 64'h1817161514131211);
    check("t5_lanes", 64'(last_lanes), 64'd8);

    // randomized traffic
    rnd_mode = 1'b1;
    for (int n = 0; n < 10000; n++)
      send_beat(IN_WIDTH'($urandom), ($urandom_range(7) == 0), 2);
    if (cur_beats.size() != 0) send_beat(IN_WIDTH'($urandom), 1'b1, 0);
    rnd_mode  = 1'b0;
    rdy_force = 1'b1;
    wait_drain("t4_drain", 200);

    // idle partial word
    send_beat(8'h21, 1'b0, 0);
    send_beat(8'h22, 1'b0, 0);
    send_beat(8'h23, 1'b0, 0);
`ifdef MULTISIM_PUSH_PACKER_TIMEOUT_EN
    model_close();
    seen = 0;
    while (exp_q.size() != 0 && seen < 60) begin
      step();
      seen++;
    end
    check("t6_flush_done", 64'(exp_q.size()), 64'd0);
    check("t6_flush_not_early", 64'(seen >= TIMEOUT_CYCLES - 1), 64'd1);
    check("t6_lanes", 64'(last_lanes), 64'd3);
`else
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_vld) seen++;
      step();
    end
    check("t6_no_flush", 64'(seen), 64'd0);
    send_beat(8'h24, 1'b1, 0);
    wait_drain("t6_drain", 20);
    check("t6_lanes", 64'(last_lanes), 64'd4);
    check("t6_data", 64'(last_data), 64'h0000000024232221);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
